// File: rtl/sram_responder.sv
`default_nettype none
// =============================================================================
// Module   : sram_responder
// Brief    : Async-SRAM protocol responder (active-low cs/oe/we) backed by an
//            inferred RAM; exposes a split data bus for a top-level tristate.
// Revision : 1.0 - initial release
// =============================================================================
module sram_responder #(
  parameter int ADDR_W   = 18,
  parameter int DW       = 16,
  parameter int AW       = 8,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [DW-1:0]     sram_data_in,
  output logic [DW-1:0]     sram_data_out,
  output logic              sram_data_oe,
  input  logic              sram_cs,
  input  logic              sram_oe,
  input  logic              sram_we,
  output logic              busy,
  output logic              err_conflict,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  // One edge is spent deciding and one reading, so latency below 2 is not achievable.
  localparam int c_LAT = (READ_LAT < 2) ? 2 : READ_LAT;
  localparam int c_CW  = $clog2(c_LAT + 1);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_RD_WAIT   = 2'd1;
  localparam logic [1:0] c_RD_DRIVE  = 2'd2;
  localparam logic [1:0] c_WR_ACTIVE = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;

  logic              r_cs;
  logic              r_oe;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DW-1:0]     r_din;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [c_CW-1:0]   r_lat_cnt;
  logic [AW-1:0]     r_hold_idx;
  logic [DW-1:0]     r_hold_data;

  logic [DW-1:0]     r_mem [0:(1<<AW)-1];

  logic              w_rd_req;
  logic              w_wr_req;
  logic              w_lat_done;
  logic              w_addr_chg;
  logic              w_latch_rd;
  logic              w_lat_inc;
  logic              w_launch;
  logic              w_hold_ld;
  logic              w_commit;

  assign w_rd_req   = ~r_cs & ~r_oe;
  assign w_wr_req   = ~r_cs & ~r_we;
  assign w_lat_done = (r_lat_cnt == c_CW'(c_LAT - 1));
  assign w_addr_chg = (r_addr != r_rd_addr);
  assign busy       = (r_state != c_IDLE);

  // Pad inputs are registered once; every decision below uses these copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs   <= 1'b1;
      r_oe   <= 1'b1;
      r_we   <= 1'b1;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_cs   <= sram_cs;
      r_oe   <= sram_oe;
      r_we   <= sram_we;
      r_addr <= sram_addr;
      r_din  <= sram_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_wr_req) begin
          w_next = c_WR_ACTIVE;
        end else if (w_rd_req) begin
          w_next = c_RD_WAIT;
        end
      end
      c_RD_WAIT, c_RD_DRIVE: begin
        if (!w_rd_req) begin
          w_next = c_IDLE;
        end else if (!r_we) begin
          w_next = c_WR_ACTIVE;
        end else if (w_addr_chg) begin
          w_next = c_RD_WAIT;
        end else if ((r_state == c_RD_WAIT) && w_lat_done) begin
          w_next = c_RD_DRIVE;
        end
      end
      c_WR_ACTIVE: begin
        if (!w_wr_req) begin
          w_next = w_rd_req ? c_RD_WAIT : c_IDLE;
        end
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_latch_rd = 1'b0;
    w_lat_inc  = 1'b0;
    w_launch   = 1'b0;
    w_commit   = 1'b0;
    w_hold_ld  = (w_next == c_WR_ACTIVE);
    case (r_state)
      c_IDLE: begin
        w_latch_rd = (w_next == c_RD_WAIT);
      end
      c_RD_WAIT: begin
        w_latch_rd = (w_next == c_RD_WAIT) && w_addr_chg;
        w_lat_inc  = (w_next == c_RD_WAIT) && !w_addr_chg;
        w_launch   = (w_next == c_RD_DRIVE);
      end
      c_RD_DRIVE: begin
        w_latch_rd = (w_next == c_RD_WAIT);
      end
      c_WR_ACTIVE: begin
        w_commit   = !w_wr_req;
        w_latch_rd = (w_next == c_RD_WAIT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr     <= '0;
      r_lat_cnt     <= '0;
      r_hold_idx    <= '0;
      r_hold_data   <= '0;
      sram_data_oe  <= 1'b0;
      sram_data_out <= '0;
      err_conflict  <= 1'b0;
      wr_count      <= '0;
      rd_count      <= '0;
    end else begin
      if (w_latch_rd) begin
        r_rd_addr <= r_addr;
        r_lat_cnt <= c_CW'(1);
      end else if (w_lat_inc) begin
        r_lat_cnt <= r_lat_cnt + c_CW'(1);
      end
      if (w_hold_ld) begin
        r_hold_idx  <= r_addr[AW-1:0];
        r_hold_data <= r_din;
      end
      sram_data_oe <= (w_next == c_RD_DRIVE);
      // A launch is always at least one edge after any commit, so it sees fresh data.
      if (w_launch) begin
        sram_data_out <= r_mem[r_rd_addr[AW-1:0]];
        rd_count      <= rd_count + 16'd1;
      end
      if (w_commit) begin
        wr_count <= wr_count + 16'd1;
      end
      if (!r_cs && !r_we && !r_oe) begin
        err_conflict <= 1'b1;
      end
    end
  end

  // Storage has no reset so it maps onto block RAM and survives rst_n.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_hold_idx] <= r_hold_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// Bench for sram_responder: directed vector table, protocol corner sequences,
// then randomized traffic checked every cycle against a request-level model.
module tb_sram_responder;

  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [17:0] sram_addr = '0;
  logic [15:0] sram_data_in = '0;
  logic        sram_cs = 1'b1;
  logic        sram_oe = 1'b1;
  logic        sram_we = 1'b1;
  logic [15:0] sram_data_out;
  logic        sram_data_oe;
  logic        busy;
  logic        err_conflict;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int n_vec = 0;
  int n_bad = 0;

  sram_responder #(
    .ADDR_W  (18),
    .DW      (16),
    .AW      (8),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sram_addr    (sram_addr),
    .sram_data_in (sram_data_in),
    .sram_data_out(sram_data_out),
    .sram_data_oe (sram_data_oe),
    .sram_cs      (sram_cs),
    .sram_oe      (sram_oe),
    .sram_we      (sram_we),
    .busy         (busy),
    .err_conflict (err_conflict),
    .wr_count     (wr_count),
    .rd_count     (rd_count)
  );

  always #5 clk = ~clk;

  // Reference model: pad values seen last edge, plus the request in flight.
  logic        s_cs, s_oe, s_we;
  logic [17:0] s_addr;
  logic [15:0] s_din;
  logic [15:0] mm [256];
  bit          kn [256];
  bit          writing, reading, driving;
  int          age;
  logic [17:0] rd_a;
  logic [7:0]  wr_idx;
  logic [15:0] wr_data;
  logic [15:0] e_dout;
  bit          e_dout_kn;
  bit          e_err;
  logic [15:0] e_wc, e_rc;

  typedef struct {
    bit          is_wr;
    logic [17:0] addr;
    logic [15:0] data;
    logic [15:0] exp_wc;
    logic [15:0] exp_rc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_start_read(input logic [17:0] a);
    reading = 1'b1;
    driving = 1'b0;
    rd_a    = a;
    age     = 1;
  endtask

  task automatic m_start_write();
    writing = 1'b1;
    wr_idx  = s_addr[7:0];
    wr_data = s_din;
  endtask

  task automatic model_reset();
    writing = 0; reading = 0; driving = 0; age = 0;
    e_dout = '0; e_dout_kn = 1; e_err = 0; e_wc = '0; e_rc = '0;
    s_cs = 1; s_oe = 1; s_we = 1; s_addr = '0; s_din = '0;
  endtask

  task automatic model_step();
    bit rq_rd, rq_wr;
    rq_rd = !s_cs && !s_oe;
    rq_wr = !s_cs && !s_we;
    if (rq_rd && rq_wr) e_err = 1'b1;
    if (writing) begin
      if (rq_wr) begin
        wr_idx  = s_addr[7:0];
        wr_data = s_din;
      end else begin
        mm[wr_idx] = wr_data;
        kn[wr_idx] = 1'b1;
        e_wc       = e_wc + 16'd1;
        writing    = 1'b0;
        if (rq_rd) m_start_read(s_addr);
      end
    end else if (reading) begin
      if (!rq_rd) begin
        reading = 0;
        driving = 0;
      end else if (!s_we) begin
        reading = 0;
        driving = 0;
        m_start_write();
      end else if (s_addr != rd_a) begin
        m_start_read(s_addr);
      end else if (!driving) begin
        age++;
        if (age == READ_LAT) begin
          driving   = 1'b1;
          e_dout    = mm[rd_a[7:0]];
          e_dout_kn = kn[rd_a[7:0]];
          e_rc      = e_rc + 16'd1;
        end
      end
    end else if (rq_wr) begin
      m_start_write();
    end else if (rq_rd) begin
      m_start_read(s_addr);
    end
  endtask

  task automatic check_all();
    chk("data_oe", sram_data_oe, driving);
    chk("busy", busy, writing || reading);
    chk("err_conflict", err_conflict, e_err);
    chk("wr_count", wr_count, e_wc);
    chk("rd_count", rd_count, e_rc);
    if (e_dout_kn) chk("data_out", sram_data_out, e_dout);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    s_cs = sram_cs; s_oe = sram_oe; s_we = sram_we; s_addr = sram_addr; s_din = sram_data_in;
    #1;
    check_all();
  endtask

  task automatic drive(input logic cs, input logic oe, input logic we,
                       input logic [17:0] a, input logic [15:0] d);
    sram_cs = cs; sram_oe = oe; sram_we = we; sram_addr = a; sram_data_in = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_data_oe", sram_data_oe, 1'b0);
    chk("rst_data_out", sram_data_out, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_count", wr_count, 16'h0);
    chk("rst_rd_count", rd_count, 16'h0);
    chk("rst_err", err_conflict, 1'b0);
    @(posedge clk);
    #1;
    drive(1, 1, 1, '0, '0);
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d);
    drive(0, 1, 0, a, d);
    repeat (3) tick();
    drive(1, 1, 1, a, d);
    repeat (3) tick();
  endtask

  task automatic do_read(input logic [17:0] a, input logic [15:0] exp);
    drive(0, 0, 1, a, '0);
    tick();
    tick();
    chk("rd_lat_oe_low", sram_data_oe, 1'b0);
    tick();
    chk("rd_oe", sram_data_oe, 1'b1);
    chk("rd_data", sram_data_out, exp);
    drive(1, 1, 1, a, '0);
    repeat (3) tick();
  endtask

  initial begin
    logic [15:0] rc0;
    int          kind, len;
    logic [17:0] a;

    tbl[0]  = '{1'b1, 18'h00012, 16'hBEEF, 16'd1, 16'd0};
    tbl[1]  = '{1'b0, 18'h00012, 16'hBEEF, 16'd1, 16'd1};
    tbl[2]  = '{1'b1, 18'h00105, 16'h1234, 16'd2, 16'd1};
    tbl[3]  = '{1'b0, 18'h00005, 16'h1234, 16'd2, 16'd2};
    tbl[4]  = '{1'b1, 18'h00010, 16'hA5A5, 16'd3, 16'd2};
    tbl[5]  = '{1'b1, 18'h00011, 16'h5A5A, 16'd4, 16'd2};
    tbl[6]  = '{1'b0, 18'h00010, 16'hA5A5, 16'd4, 16'd3};
    tbl[7]  = '{1'b0, 18'h00011, 16'h5A5A, 16'd4, 16'd4};
    tbl[8]  = '{1'b1, 18'h00030, 16'h0F0F, 16'd5, 16'd4};
    tbl[9]  = '{1'b0, 18'h3FF30, 16'h0F0F, 16'd5, 16'd5};
    tbl[10] = '{1'b1, 18'h000FF, 16'hFFFF, 16'd6, 16'd5};
    tbl[11] = '{1'b0, 18'h200FF, 16'hFFFF, 16'd6, 16'd6};

    for (int i = 0; i < 256; i++) begin
      mm[i] = '0;
      kn[i] = 1'b0;
    end
    model_reset();
    #2;
    do_reset();

    // Reset while a read is being driven
    do_write(18'h00040, 16'hC3C3);
    drive(0, 0, 1, 18'h00040, '0);
    repeat (4) tick();
    chk("pre_rst_oe", sram_data_oe, 1'b1);
    chk("pre_rst_data", sram_data_out, 16'hC3C3);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data);
      else              do_read(tbl[i].addr, tbl[i].data);
      chk("tbl_wr_count", wr_count, tbl[i].exp_wc);
      chk("tbl_rd_count", rd_count, tbl[i].exp_rc);
    end

    // Write and read strobes low together
    drive(0, 0, 0, 18'h00020, 16'h00AA);
    repeat (3) begin
      tick();
      chk("conf_oe", sram_data_oe, 1'b0);
    end
    drive(1, 1, 1, 18'h00020, '0);
    repeat (3) tick();
    chk("conf_err", err_conflict, 1'b1);
    do_read(18'h00020, 16'h00AA);
    chk("conf_err_sticky", err_conflict, 1'b1);

    // Address change while driving
    rc0 = e_rc;
    drive(0, 0, 1, 18'h00010, '0);
    repeat (3) tick();
    chk("ac_first_oe", sram_data_oe, 1'b1);
    chk("ac_first_data", sram_data_out, 16'hA5A5);
    tick();
    drive(0, 0, 1, 18'h00011, '0);
    tick();
    tick();
    chk("ac_gap_oe", sram_data_oe, 1'b0);
    tick();
    chk("ac_second_oe", sram_data_oe, 1'b1);
    chk("ac_second_data", sram_data_out, 16'h5A5A);
    chk("ac_rd_count", rd_count, rc0 + 16'd2);
    drive(1, 1, 1, '0, '0);
    repeat (3) tick();

    // Reset before the write strobe rises
    drive(0, 1, 0, 18'h00030, 16'h5555);
    repeat (2) tick();
    do_reset();
    tick();
    chk("rw_wr_count", wr_count, 16'h0);
    do_read(18'h00030, 16'h0F0F);

    for (int i = 0; i < 256; i++) do_write(18'(i), 16'($urandom));

    for (int p = 0; p < 1500; p++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 6);
      a    = 18'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
      for (int c = 0; c < len; c++) begin
        case (kind)
          0, 1:    drive(1, 1, 1, a, 16'($urandom));
          2, 3, 4: drive(0, 0, 1, a, 16'($urandom));
          5, 6:    drive(0, 1, 0, a, 16'($urandom));
          7:       drive(0, 0, 0, a, 16'($urandom));
          8:       drive(1'($urandom), 1'($urandom), 1'($urandom),
                         18'($urandom_range(0, 7)), 16'($urandom));
          default: drive(0, 0, 1, (c >= len / 2) ? (a ^ 18'h1) : a, 16'($urandom));
        endcase
        tick();
      end
      if (p == 750) do_reset();
    end

    drive(1, 1, 1, '0, '0);
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
